// File: rtl/ft2232h_rx_pkg.sv
// Shared types and constants for the FT2232H synchronous-245 read path.
package ft2232h_pkg;

   localparam int BYTE_W        = 8;
   localparam int OE_TURNAROUND = 1;

   typedef enum logic [1:0] {
      IDLE,
      OE_ON,
      READ,
      STOP
   } rx_state_t;

   // Width of an occupancy counter that must be able to hold the value depth itself.
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ft2232h_rx_if.sv
// Valid/ready byte stream between the FT2232H read path and the user logic.
interface ft2232h_rx_if;
   import ft2232h_pkg::*;

   logic [BYTE_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;

   modport master (output m_data, output m_valid, input m_ready);
   modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/ft2232h_rx_fifo.sv
// First-word-fall-through synchronous byte FIFO with registered head (dout/valid) and occupancy.
module ft2232h_rx_fifo
   import ft2232h_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [BYTE_W-1:0]          din,
   input  logic                       rd_en,
   output logic [BYTE_W-1:0]          dout,
   output logic                       valid,
   output logic [level_w(DEPTH)-1:0]  level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_w(DEPTH);

   logic [BYTE_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [LW-1:0]     r_level;
   logic [BYTE_W-1:0] r_dout;
   logic              r_valid;

   logic              w_wr;
   logic              w_rd;
   logic              w_bypass;
   logic [AW-1:0]     w_rd_ptr_nxt;
   logic [LW-1:0]     w_level_nxt;

   // A write into a full FIFO is discarded and leaves every pointer untouched.
   assign w_wr         = wr_en && (r_level != LW'(DEPTH));
   assign w_rd         = rd_en && r_valid;
   assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_rd);
   assign w_level_nxt  = r_level + LW'(w_wr) - LW'(w_rd);
   assign w_bypass     = w_wr && (r_level == LW'(w_rd));

   // NOTE: the storage array has no reset; only pointers and flags need a known state.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= din;
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_dout   <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_wr_ptr <= r_wr_ptr + AW'(w_wr);
         r_rd_ptr <= w_rd_ptr_nxt;
         r_level  <= w_level_nxt;
         r_valid  <= (w_level_nxt != '0);
         if (w_level_nxt != '0) r_dout <= w_bypass ? din : r_mem[w_rd_ptr_nxt];
      end
   end

   assign dout  = r_dout;
   assign valid = r_valid;
   assign level = r_level;

endmodule

// File: rtl/ft2232h_rx.sv
// FT2232H synchronous-245 read path: OE#/RD# burst FSM, byte capture and FWFT stream buffer.
// Define FT2232H_RX_STATS_EN to add the rx_count / rx_overflow statistics outputs.
module ft2232h_rx
   import ft2232h_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int AF_MARGIN  = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            rxf,
   output logic                            oe,
   output logic                            rd,
   input  logic [BYTE_W-1:0]               data_in,
   ft2232h_rx_if.master                    m_stream,
   output logic [level_w(FIFO_DEPTH)-1:0]  fifo_level
`ifdef FT2232H_RX_STATS_EN
   ,
   output logic [31:0]                     rx_count,
   output logic                            rx_overflow
`endif
);

   localparam int LW = level_w(FIFO_DEPTH);

   rx_state_t         r_state;
   rx_state_t         w_state_nxt;
   logic              r_oe;
   logic              r_rd;
   logic              w_oe_nxt;
   logic              w_rd_nxt;
   logic              w_capture;
   logic              w_room_idle;
   logic              w_room_read;
   logic [LW-1:0]     w_level;
   logic [BYTE_W-1:0] w_dout;
   logic              w_valid;

   // rxf comes from the chip on the same clock, so it is used unsynchronised.
   assign w_capture   = !r_rd && !rxf;
   assign w_room_idle = (FIFO_DEPTH - int'(w_level)) > AF_MARGIN;
   assign w_room_read = (FIFO_DEPTH - int'(w_level) - int'(w_capture)) > AF_MARGIN;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_oe    <= 1'b1;
         r_rd    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_oe    <= w_oe_nxt;
         r_rd    <= w_rd_nxt;
      end
   end

   // NOTE: every output is defaulted first so no path through the case infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_oe_nxt    = 1'b1;
      w_rd_nxt    = 1'b1;
      case (r_state)
         IDLE: begin
            if (!rxf && w_room_idle) begin
               w_state_nxt = OE_ON;
               w_oe_nxt    = 1'b0;
            end
         end
         OE_ON: begin
            w_oe_nxt = 1'b0;
            if (rxf) begin
               w_state_nxt = STOP;
            end else begin
               w_state_nxt = READ;
               w_rd_nxt    = 1'b0;
            end
         end
         READ: begin
            w_oe_nxt = 1'b0;
            if (rxf || !w_room_read) w_state_nxt = STOP;
            else                     w_rd_nxt    = 1'b0;
         end
         STOP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   ft2232h_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr_en (w_capture),
      .din   (data_in),
      .rd_en (m_stream.m_ready),
      .dout  (w_dout),
      .valid (w_valid),
      .level (w_level)
   );

   assign oe               = r_oe;
   assign rd               = r_rd;
   assign fifo_level       = w_level;
   assign m_stream.m_data  = w_dout;
   assign m_stream.m_valid = w_valid;

`ifdef FT2232H_RX_STATS_EN
   logic [31:0] r_rx_count;
   logic        r_rx_overflow;
   logic        w_full;

   assign w_full = (w_level == LW'(FIFO_DEPTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_count    <= '0;
         r_rx_overflow <= 1'b0;
      end else begin
         if (w_capture)           r_rx_count    <= r_rx_count + 32'd1;
         if (w_capture && w_full) r_rx_overflow <= 1'b1;
      end
   end

   assign rx_count    = r_rx_count;
   assign rx_overflow = r_rx_overflow;
`endif

endmodule

// File: tb/tb_ft2232h_rx.sv
// Bench for ft2232h_rx: cycle vector table plus chip-model bursts; define FT2232H_RX_STATS_EN for stats checks.
module tb_ft2232h_rx;
   import ft2232h_pkg::*;

   localparam int DEPTH = 16;
   localparam int AF    = 2;
   localparam int LW    = level_w(DEPTH);
   localparam int NVEC  = 17;

   typedef struct {
      logic       rxf;
      logic [7:0] din;
      logic       rdy;
      logic       oe;
      logic       rd;
      logic       valid;
      logic [7:0] data;
      int         level;
   } vec_t;

   logic          clk     = 1'b0;
   logic          rst     = 1'b1;
   logic          rxf     = 1'b1;
   logic [7:0]    data_in = 8'h00;
   logic          oe;
   logic          rd;
   logic [LW-1:0] fifo_level;
`ifdef FT2232H_RX_STATS_EN
   logic [31:0]   rx_count;
   logic          rx_overflow;
`endif

   ft2232h_rx_if u_if ();

   ft2232h_rx #(
      .FIFO_DEPTH (DEPTH),
      .AF_MARGIN  (AF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rxf         (rxf),
      .oe          (oe),
      .rd          (rd),
      .data_in     (data_in),
      .m_stream    (u_if),
      .fifo_level  (fifo_level)
`ifdef FT2232H_RX_STATS_EN
      ,
      .rx_count    (rx_count),
      .rx_overflow (rx_overflow)
`endif
   );

   always #5 clk = ~clk;

   int         errors = 0;
   int         checks = 0;
   int         idx, limit, got, cyc, max_level;
   logic [7:0] exp_byte;
   bit         chip_en = 1'b0;
   bit         mon_en  = 1'b0;
   vec_t       vt [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rx, input logic [7:0] din, input logic rdy,
                               input logic eoe, input logic erd, input logic ev,
                               input logic [7:0] ed, input int el);
      vec_t v;
      v.rxf = rx;  v.din = din; v.rdy = rdy;
      v.oe  = eoe; v.rd  = erd; v.valid = ev; v.data = ed; v.level = el;
      return v;
   endfunction

   // Chip side of the bus: byte idx is presented while idx < limit; RD# low with RXF# low pops it.
   task automatic chip_drive();
      rxf     = (idx < limit) ? 1'b0 : 1'b1;
      data_in = idx[7:0];
   endtask

   // One clock: sample at the falling edge, then update stimulus just after the rising edge.
   task automatic step();
      logic take;
      @(negedge clk);
      take = chip_en && !rd && !rxf;
      if (mon_en && !rst && u_if.m_valid && u_if.m_ready) begin
         check("stream byte", u_if.m_data, exp_byte);
         if (u_if.m_data !== exp_byte) exp_byte = u_if.m_data;
         exp_byte++;
         got++;
      end
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      @(posedge clk);
      #1;
      cyc++;
      if (take) idx++;
      if (chip_en) chip_drive();
   endtask

   task automatic restart(input int lim);
      rst = 1'b1;
      step();
      rst       = 1'b0;
      idx       = 0;
      exp_byte  = 8'h00;
      got       = 0;
      max_level = 0;
      limit     = lim;
      chip_en   = 1'b1;
      mon_en    = 1'b1;
      chip_drive();
   endtask

   task automatic wait_got(input int n, input int budget, input string name);
      for (int i = 0; i < budget && got < n; i++) step();
      check(name, got, n);
   endtask

   int t_first, t_last, lvl;

   initial begin
      vt[0]  = mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0);
      vt[1]  = mk(1'b0, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
      vt[2]  = mk(1'b0, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
      vt[3]  = mk(1'b0, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 1);
      vt[4]  = mk(1'b0, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 2);
      vt[5]  = mk(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 2);
      vt[6]  = mk(1'b0, 8'hA2, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 1);
      vt[7]  = mk(1'b0, 8'hA2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0);
      vt[8]  = mk(1'b0, 8'hA2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0);
      vt[9]  = mk(1'b0, 8'hA2, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA2, 1);
      vt[10] = mk(1'b0, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA3, 1);
      vt[11] = mk(1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0);
      vt[12] = mk(1'b1, 8'hA4, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0);
      vt[13] = mk(1'b0, 8'hA4, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
      vt[14] = mk(1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
      vt[15] = mk(1'b1, 8'hA4, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0);
      vt[16] = mk(1'b1, 8'hA4, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0);

      // Reset state
      u_if.m_ready = 1'b0;
      step();
      check("reset oe", oe, 1'b1);
      check("reset rd", rd, 1'b1);
      check("reset m_valid", u_if.m_valid, 1'b0);
      check("reset m_data", u_if.m_data, 8'h00);
      check("reset level", fifo_level, 0);
      rst = 1'b0;

      // Cycle table with rxf/data_in driven directly
      for (int i = 0; i < NVEC; i++) begin
         rxf          = vt[i].rxf;
         data_in      = vt[i].din;
         u_if.m_ready = vt[i].rdy;
         step();
         check($sformatf("vec%0d oe", i), oe, vt[i].oe);
         check($sformatf("vec%0d rd", i), rd, vt[i].rd);
         check($sformatf("vec%0d m_valid", i), u_if.m_valid, vt[i].valid);
         check($sformatf("vec%0d level", i), fifo_level, vt[i].level);
         if (vt[i].valid) check($sformatf("vec%0d m_data", i), u_if.m_data, vt[i].data);
      end

      // 600-byte burst at full rate
      u_if.m_ready = 1'b1;
      restart(600);
      step();
      check("burst oe fall", oe, 1'b0);
      check("burst rd still high", rd, 1'b1);
      step();
      check("burst rd fall", rd, 1'b0);
      step();
      check("burst first valid", u_if.m_valid, 1'b1);
      check("burst first byte", u_if.m_data, 8'h00);
      t_first = -1;
      t_last  = -1;
      for (int i = 0; i < 1000 && got < 600; i++) begin
         step();
         if (got == 1 && t_first < 0) t_first = cyc;
         if (got == 600) t_last = cyc;
      end
      check("burst count", got, 600);
      check("burst gapless span", t_last - t_first, 599);
      repeat (4) step();
      check("burst end oe", oe, 1'b1);
      check("burst end rd", rd, 1'b1);
      check("burst chip drained", idx, 600);

      // rxf rises after byte 0x37, then resumes
      restart(8'h38);
      wait_got(8'h38, 300, "pause count");
      repeat (10) step();
      check("pause oe", oe, 1'b1);
      check("pause rd", rd, 1'b1);
      check("pause level", fifo_level, 0);
      check("pause no extra bytes", got, 8'h38);
      check("pause chip index", idx, 8'h38);
      limit = 300;
      chip_drive();
      wait_got(300, 1000, "resume count");
      repeat (4) step();
      check("resume chip index", idx, 300);

      // Backpressure with rxf low
      u_if.m_ready = 1'b0;
      restart(1000);
      repeat (40) step();
      lvl = int'(fifo_level);
      check("bp level window", (lvl == DEPTH - AF) || (lvl == DEPTH - AF + 1), 1'b1);
      check("bp rd high", rd, 1'b1);
      check("bp no loss", idx, lvl);
      u_if.m_ready = 1'b1;
      step();
      u_if.m_ready = 1'b0;
      repeat (10) step();
      lvl = int'(fifo_level);
      check("bp refill window", (lvl == DEPTH - AF) || (lvl == DEPTH - AF + 1), 1'b1);
      check("bp refill no loss", idx, got + lvl);
      check("bp refill rd high", rd, 1'b1);
      u_if.m_ready = 1'b1;
      limit        = 100;
      chip_drive();
      wait_got(100, 1000, "bp drain count");

      // Random m_ready over 10k bytes
      restart(10000);
      for (int i = 0; i < 60000 && got < 10000; i++) begin
         u_if.m_ready = 1'($urandom_range(0, 1));
         step();
      end
      check("random count", got, 10000);
      check("random max level", max_level <= DEPTH - AF + 1, 1'b1);

      // One-cycle reset during READ
      u_if.m_ready = 1'b1;
      restart(1000);
      repeat (10) step();
      check("pre-reset in READ", rd, 1'b0);
      rst = 1'b1;
      step();
      check("mid reset oe", oe, 1'b1);
      check("mid reset rd", rd, 1'b1);
      check("mid reset m_valid", u_if.m_valid, 1'b0);
      check("mid reset level", fifo_level, 0);
      rst      = 1'b0;
      exp_byte = idx[7:0];
      got      = 0;
      step();
      check("post reset oe", oe, 1'b0);
      check("post reset rd", rd, 1'b1);
      wait_got(50, 200, "post reset count");

`ifdef FT2232H_RX_STATS_EN
      // Statistics
      restart(300);
      wait_got(300, 1000, "stats stream count");
      repeat (4) step();
      check("stats rx_count", rx_count, 300);
      check("stats rx_overflow clear", rx_overflow, 1'b0);
      u_if.m_ready = 1'b0;
      limit        = 1000;
      chip_drive();
      repeat (40) step();
      force dut.w_capture = 1'b1;
      repeat (3) step();
      release dut.w_capture;
      step();
      check("stats overflow set", rx_overflow, 1'b1);
      check("stats full level", fifo_level, DEPTH);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
